// File: rtl/keypad_digit_loader.sv
// rtl/keypad_digit_loader.sv - keypad synchroniser, debouncer and three-digit preset loader
// Accepted digits shift in from the right; entries the mod-6 tens stage cannot hold are rejected.
module keypad_digit_loader #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       en,
  output logic [3:0] data_mins,
  output logic [3:0] data_tens,
  output logic [3:0] data_ones,
  output logic       loadn,
  output logic       reject
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  state_t           state, state_n;
  logic [9:0]       sync1, ks;
  logic [9:0]       code, code_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       mins_n, tens_n, ones_n;
  logic             loadn_n, reject_n;
  logic             ks_valid, ks_invalid;

  function automatic logic [3:0] key_digit(input logic [9:0] c);
    key_digit = '0;
    for (int k = 0; k < 10; k++) begin
      if (c[k]) key_digit = 4'(k);
    end
  endfunction

  // exactly one key down is a valid code; two or more is a chord
  assign ks_valid   = (ks != '0) && ((ks & (ks - 10'd1)) == '0);
  assign ks_invalid = (ks != '0) && !ks_valid;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1     <= '0;
      ks        <= '0;
      code      <= '0;
      cnt       <= '0;
      state     <= S_IDLE;
      data_mins <= '0;
      data_tens <= '0;
      data_ones <= '0;
      loadn     <= 1'b1;
      reject    <= 1'b0;
    end else begin
      sync1     <= keypad;
      ks        <= sync1;
      code      <= code_n;
      cnt       <= cnt_n;
      state     <= state_n;
      data_mins <= mins_n;
      data_tens <= tens_n;
      data_ones <= ones_n;
      loadn     <= loadn_n;
      reject    <= reject_n;
    end
  end

  always_comb begin
    state_n  = state;
    code_n   = code;
    cnt_n    = cnt;
    mins_n   = data_mins;
    tens_n   = data_tens;
    ones_n   = data_ones;
    loadn_n  = 1'b1;
    reject_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (ks_valid) begin
          code_n  = ks;
          cnt_n   = CNT_W'(1);
          state_n = S_DEBOUNCE;
        end else if (ks_invalid) begin
          reject_n = 1'b1;
          cnt_n    = '0;
          state_n  = S_WAIT_RELEASE;
        end
      end

      S_DEBOUNCE: begin
        if (ks == code) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = S_ACCEPT;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (ks_invalid) begin
          reject_n = 1'b1;
          cnt_n    = '0;
          state_n  = S_WAIT_RELEASE;
        end else begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end

      S_ACCEPT: begin
        // a units digit above 5 would land in the mod-6 tens counter
        if (en || (data_ones > 4'd5)) begin
          reject_n = 1'b1;
        end else begin
          mins_n  = data_tens;
          tens_n  = data_ones;
          ones_n  = key_digit(code);
          loadn_n = 1'b0;
        end
        cnt_n   = '0;
        state_n = S_WAIT_RELEASE;
      end

      S_WAIT_RELEASE: begin
        if (ks != '0) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_digit_loader.sv
// tb/tb_keypad_digit_loader.sv - randomized self-checking bench for keypad_digit_loader
module tb_keypad_digit_loader;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       clear;
  logic [9:0] keypad;
  logic       en;
  logic [3:0] data_mins, data_tens, data_ones;
  logic       loadn, reject;

  int n_checks = 0;
  int n_errors = 0;
  int m_mins, m_tens, m_ones;

  keypad_digit_loader #(.DEBOUNCE(DB), .CNT_W(3)) dut (
    .clock(clock), .clear(clear), .keypad(keypad), .en(en),
    .data_mins(data_mins), .data_tens(data_tens), .data_ones(data_ones),
    .loadn(loadn), .reject(reject)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_digits();
    return {m_mins[3:0], m_tens[3:0], m_ones[3:0]};
  endfunction

  // Called at a negedge; asynchronous clear, then release on a later negedge.
  task automatic do_clear();
    clear = 1'b1;
    #1;
    check("clear_async", {data_mins, data_tens, data_ones, loadn, reject}, {12'h000, 1'b1, 1'b0});
    m_mins = 0; m_tens = 0; m_ones = 0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Called at a negedge. Key held for 'hold' edges, released for 'rel' edges.
  task automatic press(input string tag, input logic [9:0] code, input int hold, input int rel,
                       input logic en_val);
    int loads, rejects, load_edge, rej_edge, d, exp_rej_edge;
    bit exp_load;
    loads = 0; rejects = 0; load_edge = 0; rej_edge = 0; d = 0;
    en = en_val;
    for (int k = 0; k < 10; k++) if (code[k]) d = k;
    if ($countones(code) != 1) begin
      exp_load = 0; exp_rej_edge = 3;
    end else if (en_val || m_ones > 5) begin
      exp_load = 0; exp_rej_edge = DB + 3;
    end else begin
      exp_load = 1; exp_rej_edge = 0;
    end
    for (int i = 1; i <= hold + rel; i++) begin
      keypad = (i <= hold) ? code : 10'd0;
      @(posedge clock);
      #1;
      if (loadn === 1'b0) begin loads++; if (load_edge == 0) load_edge = i; end
      if (reject === 1'b1) begin rejects++; if (rej_edge == 0) rej_edge = i; end
      @(negedge clock);
    end
    if (exp_load) begin
      m_mins = m_tens; m_tens = m_ones; m_ones = d;
    end
    check({tag, "_loads"}, loads, exp_load ? 1 : 0);
    check({tag, "_rejects"}, rejects, exp_load ? 0 : 1);
    if (exp_load) check({tag, "_load_edge"}, load_edge, DB + 3);
    else          check({tag, "_rej_edge"}, rej_edge, exp_rej_edge);
    check({tag, "_digits"}, {data_mins, data_tens, data_ones}, model_digits());
    check({tag, "_tens_le5"}, (data_tens <= 4'd5), 1);
    en = 1'b0;
  endtask

  initial begin
    logic [9:0] code;
    int a, b, bounce_loads, bounce_rejects;
    clear = 1'b1; keypad = '0; en = 1'b0;
    m_mins = 0; m_tens = 0; m_ones = 0;
    repeat (3) @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check("idle", {data_mins, data_tens, data_ones, loadn, reject}, {12'h000, 1'b1, 1'b0});
    end
    @(negedge clock);

    press("key1", 10'd1 << 1, 10, 10, 1'b0);
    check("entry_001", {data_mins, data_tens, data_ones}, 12'h001);
    press("key3", 10'd1 << 3, 10, 10, 1'b0);
    check("entry_013", {data_mins, data_tens, data_ones}, 12'h013);
    press("key0", 10'd1 << 0, 10, 10, 1'b0);
    check("entry_130", {data_mins, data_tens, data_ones}, 12'h130);

    // clear during debounce of "9"; the still-held key is a fresh press afterwards
    keypad = 10'd1 << 9;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    do_clear();
    press("key9_after_clear", 10'd1 << 9, 12, 10, 1'b0);
    check("entry_009", {data_mins, data_tens, data_ones}, 12'h009);

    @(negedge clock);
    do_clear();
    press("hold5", 10'd1 << 5, 100, 10, 1'b0);

    bounce_loads = 0; bounce_rejects = 0;
    for (int i = 0; i < 20; i++) begin
      keypad = ((i / 2) % 2 == 0) ? 10'd1 << 2 : 10'd0;
      @(posedge clock);
      #1;
      if (loadn === 1'b0) bounce_loads++;
      if (reject === 1'b1) bounce_rejects++;
      @(negedge clock);
    end
    check("bounce_no_load", bounce_loads, 0);
    check("bounce_no_reject", bounce_rejects, 0);
    press("bounce_settle", 10'd1 << 2, 12, 10, 1'b0);
    check("entry_052", {data_mins, data_tens, data_ones}, 12'h052);

    do_clear();
    press("key7", 10'd1 << 7, 10, 10, 1'b0);
    press("mod6_guard", 10'd1 << 4, 10, 10, 1'b0);
    check("mod6_digits", {data_mins, data_tens, data_ones}, 12'h007);

    do_clear();
    press("en_lock", 10'd1 << 8, 10, 10, 1'b1);
    press("two_keys", 10'b0000100100, 10, 10, 1'b0);
    check("lock_digits", {data_mins, data_tens, data_ones}, 12'h000);

    for (int n = 0; n < 40; n++) begin
      if (m_ones > 5 && $urandom_range(0, 1) == 1) do_clear();
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        code = (10'd1 << a) | (10'd1 << b);
      end else begin
        code = 10'd1 << $urandom_range(0, 9);
      end
      press("rand", code, $urandom_range(8, 30), $urandom_range(6, 20),
            ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_digit_loader.md
Name: keypad_digit_loader

Overview:
- Upstream stage of the microwave timer: turns raw keypad presses into the three preset digits (minutes, seconds-tens, seconds-units).
- Drives the data inputs and active-low load strobe of the timer counters. The seconds-tens digit goes to the mod-6 counter.
- Synchronises and debounces keys and shifts each accepted digit in from the right, as on a real oven panel.
- Rejects entries that the mod-6 stage cannot hold.

Parameters:
- DEBOUNCE, 4, consecutive synchronised cycles a key code must be stable before acceptance (≥2).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- keypad  in  10  raw key lines, bit k = digit k, asynchronous to clock
- en  in  1  timer counting (magnetron on); keys are ignored while high
- data_mins  out  4  minutes digit to minutes counter
- data_tens  out  4  seconds-tens digit to mod-6 counter, always 0..5
- data_ones  out  4  seconds-units digit to mod-10 counter
- loadn  out  1  active-low one-cycle load strobe to all counters
- reject  out  1  one-cycle pulse when a debounced key is discarded

Behaviour:
- Reset: already decided. One clock; reset is asynchronous and active-high. Port names are clock and clear.
- While clear=1: data_* = 0, loadn = 1, reject = 0, synchroniser = 0, counter = 0, state = IDLE. Release is synchronous to the next edge.
- keypad passes through a 2-flop synchroniser; only the synchronised value (ks) is used.
- A valid code is exactly one bit set. An invalid code has two or more bits set.
- Key digit = index of the set bit (4-bit).
- FSM states: IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE.
- IDLE:
  - ks == 0: stay.
  - ks valid: latch code, cnt = 1, go to DEBOUNCE.
  - ks invalid: pulse reject, go to WAIT_RELEASE.
- DEBOUNCE:
  - ks == latched code: cnt++; when cnt reaches DEBOUNCE, go to ACCEPT.
  - ks == 0 or a different valid code: go to IDLE, cnt = 0, no reject.
  - ks invalid: pulse reject, go to WAIT_RELEASE.
- ACCEPT (exactly one cycle), evaluated on the edge leaving ACCEPT:
  - Reject (reject = 1 for one cycle, digits unchanged, loadn stays 1) if en = 1, or if data_ones > 5, since that value would shift into data_tens.
  - Otherwise shift: data_mins <= data_tens, data_tens <= data_ones, data_ones <= digit. The old data_mins is discarded. loadn = 0 for exactly one cycle.
  - Always go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Needs ks == 0 for DEBOUNCE consecutive cycles, then go to IDLE.
  - Any nonzero ks restarts the release count.
  - A held key therefore never auto-repeats.
- Latency: keypad held stable from before edge 1 gives digits updated and loadn low at edge DEBOUNCE+3. With DEBOUNCE = 4 that is edge 7.
- Outputs loadn, reject and data_* are registered. No combinational path from keypad or en to any output.
- data_tens is never above 5 by construction. data_mins may hold 0..9.
- en rising mid-debounce does not abort the debounce; it only forces rejection at ACCEPT.
- clear asserted in any state aborts immediately to reset values. A key still held after release of clear is treated as a fresh press.

Test Plan:
- Reset/idle: clear=1 then 0, keypad=0 for 20 cycles → data_* = 0, loadn = 1, reject = 0 throughout.
- Entry "1","3","0" with DEBOUNCE=4, each key held 10 cycles and released 10 cycles:
  - After the presses: (mins, tens, ones) = (0,0,1), then (0,1,3), then (1,3,0).
  - loadn low for exactly one cycle, at edge 7 of each press.
  - Hold "5" for 100 cycles → exactly one loadn pulse.
- Bounce: keypad toggles bit 2 every 2 cycles for 20 cycles, then holds it steady → no loadn during the bouncing; one accepted "2" after stable DEBOUNCE+3 edges.
- Mod-6 guard: digits (0,0,7), press "4" → reject pulses once; digits stay (0,0,7); loadn stays 1.
- Lockouts:
  - en=1, press "8" → reject pulse, digits unchanged.
  - Keypad = 10'b0000100100 (two keys) → reject pulse, no load; no further action until keypad = 0 for DEBOUNCE cycles.
- Clear mid-operation: assert clear during DEBOUNCE of "9" with digits (1,3,0) → immediate reset to (0,0,0), loadn = 1; key still held after release → accepted "9", giving (0,0,9).
